// File: rtl/cache_line_mem_responder.sv
// rtl/cache_line_mem_responder.sv - line-fill / write-back memory responder with programmable latency
// Optional: CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN adds err and suppresses out-of-range accesses.
module cache_line_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  rdata_last,
    output logic                  busy,
    output logic                  done
`ifdef CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int LINE_W = IDX_W - OFF_W;
    localparam int CNT_W  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_DONE} state_t;

    state_t                  state_q;
    logic [LINE_W-1:0]       line_q;
    logic [OFF_W-1:0]        beat_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    we_q;
    logic                    oor_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rdata_valid_q;
    logic                    rdata_last_q;
    logic                    wdata_ready_q;
    logic                    done_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    logic [LINE_W-1:0]       req_line;
    logic                    req_oor;
    logic                    addr_unused;
    logic                    start_d;
    logic                    start_we_d;
    logic [LINE_W-1:0]       start_line_d;
    logic                    start_oor_d;
    logic                    mem_we;

    // Line number within storage; the upper address bits wrap unless range checking is on.
    assign req_line = req_addr[IDX_W+1:OFF_W+2];

`ifdef CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN
    assign req_oor     = |req_addr[ADDR_WIDTH-1:IDX_W+2];
    assign err         = err_q;
    assign addr_unused = ^req_addr[OFF_W+1:0];
`else
    assign req_oor     = 1'b0;
    assign addr_unused = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[OFF_W+1:0], err_q};
`endif

    assign req_ready   = rst && (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;
    assign wdata_ready = wdata_ready_q;
    assign done        = done_q;

    function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [LINE_W-1:0] line,
                                                      input logic [OFF_W-1:0]  beat,
                                                      input logic              oor);
        rd_word = oor ? '0 : mem_q[{line, beat}];
    endfunction

    // Burst entry comes either straight from the handshake (zero latency) or from the wait countdown.
    always_comb begin
        start_d      = 1'b0;
        start_we_d   = we_q;
        start_line_d = line_q;
        start_oor_d  = oor_q;
        if (state_q == S_IDLE && req_valid && LATENCY == 0) begin
            start_d      = 1'b1;
            start_we_d   = req_we;
            start_line_d = req_line;
            start_oor_d  = req_oor;
        end else if (state_q == S_WAIT && cnt_q == CNT_W'(1)) begin
            start_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            line_q        <= '0;
            beat_q        <= '0;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            oor_q         <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            wdata_ready_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        line_q  <= req_line;
                        we_q    <= req_we;
                        oor_q   <= req_oor;
                        cnt_q   <= CNT_W'(LATENCY);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: cnt_q <= cnt_q - 1'b1;
                S_READ: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q       <= S_DONE;
                        done_q        <= 1'b1;
                        err_q         <= oor_q;
                        rdata_q       <= '0;
                        rdata_valid_q <= 1'b0;
                        rdata_last_q  <= 1'b0;
                    end else begin
                        beat_q       <= beat_q + 1'b1;
                        rdata_q      <= rd_word(line_q, beat_q + 1'b1, oor_q);
                        rdata_last_q <= (beat_q + 1'b1 == LAST_BEAT);
                    end
                end
                S_WRITE: begin
                    if (wdata_valid) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q       <= S_DONE;
                            done_q        <= 1'b1;
                            err_q         <= oor_q;
                            wdata_ready_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (start_d) begin
                beat_q <= '0;
                if (start_we_d) begin
                    state_q       <= S_WRITE;
                    wdata_ready_q <= 1'b1;
                end else begin
                    state_q       <= S_READ;
                    rdata_q       <= rd_word(start_line_d, '0, start_oor_d);
                    rdata_valid_q <= 1'b1;
                    rdata_last_q  <= 1'b0;
                end
            end
        end
    end

    // Storage is deliberately not reset so system memory survives a CPU reset.
    assign mem_we = (state_q == S_WRITE) && wdata_valid && !oor_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[{line_q, beat_q}] <= wdata;
        end
    end

endmodule

// File: tb/tb_cache_line_mem_responder.sv
// tb/tb_cache_line_mem_responder.sv - scoreboard bench for cache_line_mem_responder
module tb_cache_line_mem_responder;

    localparam int LW = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_last;
    logic        busy;
    logic        done;
`ifdef CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN
    logic        err;
`endif

    cache_line_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .DEPTH_WORDS(1024), .LATENCY(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
        .busy(busy), .done(done)
`ifdef CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN
        , .err(err)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [32:0] rd_q [$];
    logic        done_q [$];

    logic [3:0][31:0] L40 = {32'h44, 32'h33, 32'h22, 32'h11};
    logic [3:0][31:0] L80 = {32'h88, 32'h77, 32'h66, 32'h55};
    logic [3:0][31:0] LA0 = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    logic [3:0][31:0] LDE = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
    logic [3:0][31:0] LZ  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected beats/completions whenever the DUT presents them.
    always @(negedge clk) begin
        logic [32:0] eb;
        logic        ee;
        if (rst) begin
            if (rdata_valid) begin
                if (rd_q.size() == 0) chk("beat_expected", rd_q.size(), 1);
                else begin
                    eb = rd_q.pop_front();
                    chk("rdata", rdata, eb[31:0]);
                    chk("rdata_last", rdata_last, eb[32]);
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_expected", done_q.size(), 1);
                else begin
                    ee = done_q.pop_front();
`ifdef CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN
                    chk("err", err, ee);
`endif
                end
            end
        end
    end

    task automatic wait_sig(input int which, input string nm, output int c);
        logic s;
        c = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            case (which)
                0:       s = rdata_valid;
                1:       s = wdata_ready;
                default: s = done;
            endcase
            if (s) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk({"timeout_", nm}, 0, 1);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input bit hold, output int acc);
        acc = -1;
        req_we = we;
        req_addr = addr;
        req_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("timeout_accept", 0, 1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic push_read(input logic [3:0][31:0] d, input int n);
        for (int i = 0; i < n; i++) rd_q.push_back({(i == LW - 1) ? 1'b1 : 1'b0, d[i]});
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0][31:0] d, input logic e_err,
                           input string nm);
        int acc, c;
        push_read(d, 4);
        done_q.push_back(e_err);
        issue(1'b0, addr, 1'b0, acc);
        wait_sig(0, "rvalid", c);
        chk({nm, "_first_beat_delay"}, c - acc, 5);
        wait_sig(2, "done", c);
        chk({nm, "_done_delay"}, c - acc, 9);
        @(posedge clk); #1;
    endtask

    task automatic write_data(input int acc, input logic [3:0][31:0] d, input int stall, input string nm);
        int c;
        bit busy_ok;
        busy_ok = 1'b1;
        for (int i = 0; i < LW; i++) begin
            wdata = d[i];
            wdata_valid = 1'b1;
            wait_sig(1, "wready", c);
            if (i == 0) chk({nm, "_wready_delay"}, c - acc, 5);
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            if (i == 1 && stall > 0) begin
                wdata_valid = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    if (!busy) busy_ok = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
        wdata_valid = 1'b0;
        wait_sig(2, "done", c);
        chk({nm, "_done_delay"}, c - acc, 9 + stall);
        chk({nm, "_busy_held"}, busy_ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0][31:0] d, input int stall,
                            input logic e_err, input string nm);
        int acc;
        done_q.push_back(e_err);
        issue(1'b1, addr, 1'b0, acc);
        write_data(acc, d, stall, nm);
    endtask

    initial begin
        int accA, accB, dcyc, c0;
        bit rdy_ok;
        rst = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        wdata = '0;
        wdata_valid = 1'b0;
        #12;
        chk("reset_rdata_valid", rdata_valid, 0);
        chk("reset_rdata_last", rdata_last, 0);
        chk("reset_wdata_ready", wdata_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rdata", rdata, 0);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", req_ready, 1);

        do_write(32'h40, L40, 0, 1'b0, "t1w");
        do_read(32'h40, L40, 1'b0, "t1r");
        do_read(32'h4C, L40, 1'b0, "t2");
        do_write(32'h80, L80, 2, 1'b0, "t3w");
        do_read(32'h80, L80, 1'b0, "t3r");

        // Held request: read 0x40 then write 0x80 without dropping req_valid.
        push_read(L40, 4);
        done_q.push_back(1'b0);
        done_q.push_back(1'b0);
        rdy_ok = 1'b1;
        dcyc = -1;
        issue(1'b0, 32'h40, 1'b1, accA);
        req_we = 1'b1;
        req_addr = 32'h80;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready) rdy_ok = 1'b0;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        chk("t4_ready_low", rdy_ok, 1);
        chk("t4_done_delay", dcyc - accA, 9);
        @(negedge clk);
        chk("t4_ready_after_done", req_ready, 1);
        accB = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        write_data(accB, LA0, 0, "t4w");
        do_read(32'h80, LA0, 1'b0, "t4r");

        // Reset during read beat 2.
        push_read(L40, 2);
        issue(1'b0, 32'h40, 1'b0, accA);
        wait_sig(0, "t5_rvalid", c0);
        @(posedge clk);
        @(posedge clk); #2;
        chk("t5_beat2_visible", rdata_valid, 1);
        rst = 1'b0;
        #1;
        chk("t5_async_rdata_valid", rdata_valid, 0);
        chk("t5_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_after_reset", req_ready, 1);
        @(posedge clk); #1;
        do_read(32'h40, L40, 1'b0, "t5r");

`ifdef CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN
        do_read(32'h1040, LZ, 1'b1, "t6r");
        do_write(32'h1040, LDE, 0, 1'b1, "t6w");
        do_read(32'h40, L40, 1'b0, "t6chk");
`else
        do_read(32'h1040, L40, 1'b0, "t6r");
`endif

        repeat (3) @(posedge clk);
        chk("rd_queue_empty", rd_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_line_mem_responder.md
Name: cache_line_mem_responder

Overview:
- Main-memory responder on the backing side of the 5-stage RISC-V CPU's data/instruction caches.
- Accepts line-fill (read) and write-back (write) requests from a cache controller.
- Waits a programmable access latency, then streams one cache line word-by-word.
- Holds the word-addressed storage array used as system memory in CPU testbenches.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr
DATA_WIDTH, 32, word width of wdata/rdata
LINE_WORDS, 4, words per cache line (power of two, >=2)
DEPTH_WORDS, 1024, storage depth in words (power of two)
LATENCY, 4, wait cycles between request acceptance and first data beat (>=0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  cache presents a line request
req_ready  output  1  responder can accept a request (high only in IDLE)
req_we  input  1  1 = write-back, 0 = line fill
req_addr  input  ADDR_WIDTH  byte address of the line (low bits ignored)
wdata  input  DATA_WIDTH  write-back beat data
wdata_valid  input  1  write beat present
wdata_ready  output  1  responder accepts write beat
rdata  output  DATA_WIDTH  fill beat data
rdata_valid  output  1  fill beat valid (no backpressure)
rdata_last  output  1  final fill beat
busy  output  1  request in progress (state != IDLE)
done  output  1  one-cycle pulse when request completes

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low.
- Reset (rst=0):
  - State goes to IDLE immediately.
  - Outputs: rdata_valid, rdata_last, wdata_ready, busy, done = 0; rdata = 0.
  - req_ready = 1 once rst is high in IDLE.
  - Storage contents are not reset and are preserved across reset.
- Line base: req_addr is treated as byte address.
  - Base word index = (req_addr >> 2) with low log2(LINE_WORDS) bits cleared, modulo DEPTH_WORDS.
  - Beat i uses index base+i, with no carry beyond the line.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&req_ready, latch base and req_we, and load the latency counter with LATENCY. Next state is WAIT, or the burst state directly if LATENCY=0.
  - WAIT: counter decrements each cycle. On the cycle it equals 1, next state is READ_BURST or WRITE_BURST.
  - READ_BURST:
    - rdata and rdata_valid are registered; the beat counter advances every cycle.
    - rdata_last=1 together with beat LINE_WORDS-1.
    - After the last beat, next state is DONE.
    - The cache must sample every beat; there is no stall.
  - WRITE_BURST:
    - wdata_ready=1.
    - Each cycle with wdata_valid=1 writes wdata to base+beat and advances the beat counter.
    - wdata_valid=0 holds the beat counter; no timeout.
    - After beat LINE_WORDS-1 is written, next state is DONE.
  - DONE: done=1 for exactly one cycle, req_ready=0, then IDLE.
- Timing:
  - The first rdata_valid is asserted in the cycle LATENCY+1 cycles after the accepting cycle. The accepting cycle is the cycle where req_valid&req_ready=1.
  - wdata_ready rises at the same point.
  - done follows the last beat by one cycle.
  - A new request is accepted no earlier than the cycle after done. A req_valid held high during a transaction is ignored until IDLE.
- Request fields: req_we, req_addr and wdata_valid are ignored outside their active states.
- Reset mid-transaction: the partial write-back leaves already-written beats in storage, and unwritten beats unchanged. No done pulse.

Optional Feature:
- Macro: CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN.
- Defined:
  - Adds output port err (1 bit).
  - A request whose word index (req_addr>>2) >= DEPTH_WORDS is still handshaken normally.
  - Read beats return rdata=0, and writes are suppressed.
  - err=1 for the single DONE cycle, coincident with done. err resets to 0.
- Undefined:
  - No err port.
  - Out-of-range addresses wrap modulo DEPTH_WORDS.

Test Plan:
1. Write then read back (LATENCY=4, LINE_WORDS=4).
   - Stimulus: after reset, write request at 0x40 with wdata 0x11,0x22,0x33,0x44 back-to-back, then a read request at 0x40.
   - Write: wdata_ready rises 5 cycles after accept, and done pulses 1 cycle after beat 3.
   - Read: first rdata_valid 5 cycles after accept, data 0x11,0x22,0x33,0x44, rdata_last only on 0x44, done the next cycle.
2. Unaligned read.
   - Stimulus: read at 0x4C after scenario 1.
   - Required: same four words starting at 0x11, because the base is 0x40.
3. Write stall.
   - Stimulus: write at 0x80 with wdata_valid low for 2 cycles after beat 1.
   - Required: beats stored at 0x80..0x8C as sent; done arrives exactly 2 cycles later than the unstalled case; busy stays high throughout.
4. Held request.
   - Stimulus: req_valid held high across a read at 0x40 followed by a write at 0x80.
   - Required: req_ready=0 from accept through done; the second request is accepted in the cycle right after done.
5. Mid-burst reset.
   - Stimulus: rst=0 during read beat 2.
   - Required: rdata_valid and busy drop without waiting for an edge; after release, req_ready=1; re-reading 0x40 still returns 0x11..0x44.
6. Out-of-range request (DEPTH_WORDS=1024).
   - Stimulus: read at 0x1040.
   - Without macro: returns the 0x40 line.
   - With CACHE_LINE_MEM_RESPONDER_ADDR_CHECK_EN: rdata=0 on all beats and err=1 with done. A write to 0x1040 leaves the 0x40 line unchanged.
